// File: rtl/conv3x3_mac_top.sv
// 3x3 int8 convolution MAC: one window dotted with a stored filter per clock,
// fixed two-cycle latency from ifmap_in to psumOut.
module conv3x3_mac_top #(
    parameter int DATA_W = 8,
    parameter int NUM_EL = 9,
    parameter int OUT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     state,
    input  logic [NUM_EL*DATA_W-1:0] ifmap_in,
    input  logic [NUM_EL*DATA_W-1:0] filter_in,
    output logic [OUT_W-1:0]         psumOut
);

    localparam int PROD_W = 2 * DATA_W;
    // Accumulator wide enough that nine products never overflow before truncation.
    localparam int ACC_W  = (OUT_W > PROD_W + 4) ? OUT_W : PROD_W + 4;

    logic [NUM_EL*DATA_W-1:0] w_r;
    logic [NUM_EL*DATA_W-1:0] x_r;
    logic signed [PROD_W-1:0] p_r [NUM_EL];
    logic [OUT_W-1:0]         psum_r;
    logic signed [ACC_W-1:0]  acc_s;

    function automatic logic signed [PROD_W-1:0] mul_el(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic signed [PROD_W-1:0] a_ext;
        logic signed [PROD_W-1:0] b_ext;
        a_ext = PROD_W'(a);
        b_ext = PROD_W'(b);
        return a_ext * b_ext;
    endfunction

    // Weight register: loaded only while state is high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            w_r <= '0;
        end else if (state) begin
            w_r <= filter_in;
        end else begin
            w_r <= w_r;
        end
    end

    // Stage 0 (input capture) and stage 1 (element-wise products).
    always_ff @(posedge clk) begin
        if (!rst) begin
            x_r <= '0;
            for (int k = 0; k < NUM_EL; k++) begin
                p_r[k] <= '0;
            end
        end else begin
            x_r <= ifmap_in;
            for (int k = 0; k < NUM_EL; k++) begin
                p_r[k] <= mul_el(x_r[k*DATA_W +: DATA_W], w_r[k*DATA_W +: DATA_W]);
            end
        end
    end

    // Sign-extended adder tree over the registered products.
    always_comb begin
        acc_s = '0;
        for (int k = 0; k < NUM_EL; k++) begin
            acc_s = acc_s + ACC_W'(p_r[k]);
        end
    end

    // Stage 2: wrap the sum to the output width.
    always_ff @(posedge clk) begin
        if (!rst) begin
            psum_r <= '0;
        end else begin
            psum_r <= acc_s[OUT_W-1:0];
        end
    end

    assign psumOut = psum_r;

endmodule

// File: tb/tb_conv3x3_mac_top.sv
// Self-checking bench for conv3x3_mac_top: directed plan steps followed by
// randomized traffic, compared against a two-deep queue of expected dot products.
module tb_conv3x3_mac_top;

    logic        clk;
    logic        rst;
    logic        state;
    logic [71:0] ifmap_in;
    logic [71:0] filter_in;
    logic [15:0] psumOut;

    int checks;
    int fails;

    // Reference model: current weights and the sums still in flight.
    logic [71:0] m_w;
    logic [15:0] pend0;
    logic [15:0] pend1;
    logic [15:0] psum_exp;

    conv3x3_mac_top dut (
        .clk      (clk),
        .rst      (rst),
        .state    (state),
        .ifmap_in (ifmap_in),
        .filter_in(filter_in),
        .psumOut  (psumOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] dot9(input logic [71:0] a, input logic [71:0] b);
        int  s;
        byte ea;
        byte eb;
        logic [31:0] s_bits;
        s = 0;
        for (int k = 0; k < 9; k++) begin
            ea = a[8*k +: 8];
            eb = b[8*k +: 8];
            s = s + int'(ea) * int'(eb);
        end
        s_bits = s;
        return s_bits[15:0];
    endfunction

    function automatic logic [71:0] diag(input logic [7:0] v);
        logic [71:0] r;
        r = 72'h0;
        r[71:64] = v;
        r[39:32] = v;
        r[7:0]   = v;
        return r;
    endfunction

    function automatic logic [71:0] rnd72();
        return {$urandom(), $urandom(), 8'($urandom())};
    endfunction

    task automatic check_model(input string tag);
        checks++;
        assert (psumOut === psum_exp) else begin
            fails++;
            $error("FAIL %s: psumOut=%h expected=%h", tag, psumOut, psum_exp);
        end
    endtask

    task automatic check_const(input string tag, input logic [15:0] exp);
        checks++;
        assert (psumOut === exp) else begin
            fails++;
            $error("FAIL %s: psumOut=%h expected=%h", tag, psumOut, exp);
        end
    endtask

    // Drive one cycle at the falling edge, clock it, advance the model, compare.
    task automatic step(input logic r, input logic s, input logic [71:0] im,
                        input logic [71:0] fl, input string tag);
        rst       = r;
        state     = s;
        ifmap_in  = im;
        filter_in = fl;
        @(posedge clk);
        if (!r) begin
            m_w      = 72'h0;
            pend0    = 16'h0;
            pend1    = 16'h0;
            psum_exp = 16'h0;
        end else begin
            if (s) m_w = fl;
            psum_exp = pend1;
            pend1    = pend0;
            pend0    = dot9(im, m_w);
        end
        @(negedge clk);
        check_model(tag);
    endtask

    initial begin
        checks    = 0;
        fails     = 0;
        m_w       = 72'h0;
        pend0     = 16'h0;
        pend1     = 16'h0;
        psum_exp  = 16'h0;
        rst       = 1'b0;
        state     = 1'b0;
        ifmap_in  = 72'h0;
        filter_in = 72'h0;
        @(negedge clk);

        // Reset with arbitrary inputs
        step(1'b0, 1'b1, rnd72(), rnd72(), "reset0");
        step(1'b0, 1'b1, rnd72(), rnd72(), "reset1");
        check_const("reset_zero", 16'h0000);

        // Released, weights still zero
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, {9{8'h05}}, rnd72(), "zero_w");
        check_const("zero_weights", 16'h0000);

        // Diagonal filter with simultaneous load, then weight hold
        step(1'b1, 1'b1, 72'h010203040506070809, 72'h010000000100000001, "diag_load");
        step(1'b1, 1'b0, 72'h010203040506070809, {9{8'h7F}}, "diag_hold0");
        step(1'b1, 1'b0, 72'h010203040506070809, {9{8'h7F}}, "diag_hold1");
        check_const("diag_sum", 16'h000F);
        step(1'b1, 1'b0, 72'h010203040506070809, {9{8'h7F}}, "diag_hold2");
        step(1'b1, 1'b0, 72'h010203040506070809, {9{8'h7F}}, "diag_hold3");
        check_const("weight_hold", 16'h000F);

        // Signed arithmetic
        step(1'b1, 1'b1, {9{8'hFF}}, {9{8'h01}}, "signed_load");
        step(1'b1, 1'b0, {9{8'hFF}}, 72'h0, "signed1");
        step(1'b1, 1'b0, {9{8'hFF}}, 72'h0, "signed2");
        check_const("signed_neg9", 16'hFFF7);

        // Overflow wrap
        step(1'b1, 1'b1, {9{8'h80}}, {9{8'h80}}, "ovf_load");
        step(1'b1, 1'b0, {9{8'h80}}, 72'h0, "ovf1");
        step(1'b1, 1'b0, {9{8'h80}}, 72'h0, "ovf2");
        check_const("overflow_wrap", 16'h4000);

        // Streaming latency with the diagonal filter
        step(1'b1, 1'b1, 72'h0, 72'h010000000100000001, "strm_load");
        step(1'b1, 1'b0, diag(8'd1), 72'h0, "strm_w1");
        step(1'b1, 1'b0, diag(8'd2), 72'h0, "strm_w2");
        check_const("strm_before", 16'h0000);
        step(1'b1, 1'b0, diag(8'd3), 72'h0, "strm_w3");
        check_const("strm_3", 16'h0003);
        step(1'b1, 1'b0, diag(8'd4), 72'h0, "strm_w4");
        check_const("strm_6", 16'h0006);
        step(1'b1, 1'b0, diag(8'd5), 72'h0, "strm_w5");
        check_const("strm_9", 16'h0009);

        // Mid-stream reset discards in-flight sums
        step(1'b0, 1'b0, diag(8'd6), 72'h0, "mid_rst");
        check_const("mid_rst_zero", 16'h0000);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, diag(8'd7), 72'h0, "post_rst");
            check_const("no_stale", 16'h0000);
        end

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 31) != 0), ($urandom_range(0, 3) == 0),
                 rnd72(), rnd72(), "random");
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/conv3x3_mac_top.md
Name:
conv3x3_mac_top

Overview:
- Top level of the 3x3 convolution datapath: one 3x3 int8 input window dotted with one 3x3 int8 filter per clock.
- Filter weights are held in an internal weight register, loaded when `state`=1.
- Each cycle a fresh 9-byte ifmap window is accepted; a 16-bit partial sum is produced through a fixed 2-cycle pipeline.
- Sits between the window/line-buffer feeder and the psum accumulation/writeback logic.

Parameters:
- DATA_W, 8, width of each ifmap and filter element (signed two's complement).
- NUM_EL, 9, elements per window (3x3).
- OUT_W, 16, width of psumOut.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset), sampled on clk rising edge.
- state  in  1  1 = load filter_in into the weight register this cycle; 0 = hold weights.
- ifmap_in  in  72  nine signed 8-bit window elements; element k = ifmap_in[8k+7:8k], k=0..8; k=8 is top-left, row-major down to k=0 = bottom-right.
- filter_in  in  72  nine signed 8-bit weights, same packing as ifmap_in.
- psumOut  out  16  signed dot product of window and weights, mod 2^16.

Behaviour:
- Reset (rst=0 at a rising edge): clear the weight register W, the input register X, all nine product registers P[k] and psumOut to 0.
  - psumOut reads 0x0000 after that edge.
  - Reset applied mid-stream discards all in-flight data.
- Weight register: on a rising edge with rst=1 and state=1, W <= filter_in. With state=0, W holds its value.
  - filter_in is ignored whenever state=0.
- Stage 0: every rising edge with rst=1, X <= ifmap_in. No valid/enable; a new window is accepted every cycle.
- Stage 1: P[k] <= signed(X[k]) * signed(W[k]) for all k.
  - Each product is a full 16-bit signed result; 8x8 signed always fits.
- Stage 2: psumOut <= sum of P[0..8], computed with sign extension and truncated to 16 bits.
  - Wrap-around is modulo 2^16; no saturation.
- Latency: an ifmap_in sampled at edge N appears on psumOut after edge N+2. Throughput is 1 window per cycle.
- Simultaneous load: if state=1 at edge N, the ifmap sampled at edge N is multiplied by the newly loaded weights, since stage 1 at edge N+1 reads the updated W.
- After reset, W=0, so psumOut stays 0 until weights are loaded via state=1.
- The adder tree may be pipelined internally only if the total latency stays exactly 2 cycles.
- No other outputs, no handshake, no X propagation when inputs are stable.

Test Plan:
- Reset: hold rst=0 for 2 edges with arbitrary inputs -> psumOut=0x0000. Release rst, keep state=0 with ifmap=all 0x05 -> psumOut stays 0x0000 (weights zero).
- Diagonal filter: rst=1, state=1 for one cycle with filter_in=72'h010000000100000001 and ifmap_in=72'h010203040506070809 -> two edges later psumOut=0x000F (1+5+9).
- Signed arithmetic: filter_in all 0x01 (loaded via state=1), ifmap_in all 0xFF -> psumOut=0xFFF7 (-9).
- Overflow wrap: filter all 0x80, ifmap all 0x80 -> psumOut=0x4000 (147456 mod 65536).
- Weight hold: after loading the diagonal filter, drive state=0 with filter_in=all 0x7F and ifmap=72'h010203040506070809 -> psumOut remains 0x000F.
- Streaming/latency: after loading the diagonal filter, drive back-to-back windows with diagonal values (a,b,c) = (1,1,1), (2,2,2), (3,3,3) -> psumOut = 0x0003, 0x0006, 0x0009 on consecutive cycles, each exactly 2 edges after its input. Assert rst=0 mid-stream -> psumOut=0 after the next edge, and no stale sums appear after release.
